rx_drain_ctrl: RTL and testbench

- Sequences reads from the UART receive word buffer and streams its contents out as single words over a valid/ready handshake.
- Sits between the receive wrapper's parallel buffer port and the downstream consumer.
- Also keeps saturating counts of parity and stop-bit errors and a sticky overrun flag.

---
 rtl/rx_ctrl_pkg.sv | 16 +
 rtl/rx_err_counter.sv | 34 +++
 rtl/rx_drain_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rx_drain_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared types and helpers for the receive-buffer drain controller.
// Optional feature macro: RX_CTRL_STALL_DROP_EN (stall timeout / word drop).
package rx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2
  } state_t;

  // Width of the word index register; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rx_err_counter.sv
// Rising-edge detector feeding a saturating event counter.
// Clear is synchronous and wins over a same-cycle increment.
// Optional feature macro: RX_CTRL_STALL_DROP_EN (not used in this file).
module rx_err_counter #(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     err_in,
  input  logic                     clear,
  output logic [ERR_CNT_WIDTH-1:0] count
);

  logic                     prev_reg;
  logic [ERR_CNT_WIDTH-1:0] count_reg;

  // Track previous input level and count 0->1 transitions, holding at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      prev_reg <= err_in;
      if (clear) begin
        count_reg <= '0;
      end else if (err_in && !prev_reg && (count_reg != '1)) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/rx_drain_ctrl.sv
// Drains the UART receive word buffer: one read pulse per full buffer, then
// streams the captured words out one at a time over valid/ready.
// Also keeps saturating parity/stop error counts and a sticky overrun flag.
// Optional feature macro: RX_CTRL_STALL_DROP_EN -- drop the remaining words
// after STALL_LIMIT consecutive stalled cycles and flag it on stall_drop.
module rx_drain_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int NO_OF_WORS_IN_BUFFER = 2,
  parameter int NO_OF_DATA_BITS      = 7,
  parameter int ERR_CNT_WIDTH        = 8,
  parameter int STALL_LIMIT          = 1024
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            rx_buffer_full,
  input  logic [NO_OF_WORS_IN_BUFFER*NO_OF_DATA_BITS-1:0] data_parallel_in,
  output logic                                            data_parallel_rd_enable,
  input  logic                                            parity_error,
  input  logic                                            stop_bit_error,
  output logic [NO_OF_DATA_BITS-1:0]                      word_out,
  output logic                                            word_valid,
  input  logic                                            word_ready,
  output logic                                            busy,
  output logic [ERR_CNT_WIDTH-1:0]                        parity_err_count,
  output logic [ERR_CNT_WIDTH-1:0]                        stop_err_count,
  output logic                                            overrun,
`ifdef RX_CTRL_STALL_DROP_EN
  output logic                                            stall_drop,
`endif
  input  logic                                            status_clear
);

  localparam int N     = NO_OF_WORS_IN_BUFFER;
  localparam int W     = NO_OF_DATA_BITS;
  localparam int IDX_W = idx_width(N);

  // Reject unsupported configurations at elaboration time.
  if (((W != 6) && (W != 7) && (W != 8)) || (N < 1) || (STALL_LIMIT < 1)) begin : g_bad_cfg
    $error("rx_drain_ctrl: unsupported parameter combination");
  end

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] index_reg, index_next;
  logic [W-1:0]     shadow_reg [N];
  logic             prev_full_reg;
  logic             overrun_reg;
  logic             handshake;
  logic             last_word;
  logic             stall_hit;

  assign handshake = (state_reg == SEND) && word_ready;
  assign last_word = (index_reg == IDX_W'(N - 1));

  // State and word index register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      index_reg <= '0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
    end
  end

  // Next-state logic: capture once per full buffer, then walk the words.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    case (state_reg)
      IDLE: begin
        if (rx_buffer_full) state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = SEND;
        index_next = '0;
      end
      SEND: begin
        if (handshake) begin
          if (last_word) begin
            state_next = IDLE;
            index_next = '0;
          end else begin
            index_next = index_reg + 1'b1;
          end
        end else if (stall_hit) begin
          state_next = IDLE;
          index_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

  // Shadow copy of each buffer word, taken only at the edge that ends CAPTURE.
  for (genvar gi = 0; gi < N; gi++) begin : g_shadow
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        shadow_reg[gi] <= '0;
      end else if (state_reg == CAPTURE) begin
        shadow_reg[gi] <= data_parallel_in[gi*W +: W];
      end
    end
  end

  // Overrun: buffer went full again while the previous contents are still draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_full_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      prev_full_reg <= rx_buffer_full;
      if (status_clear) begin
        overrun_reg <= 1'b0;
      end else if ((state_reg == SEND) && rx_buffer_full && !prev_full_reg) begin
        overrun_reg <= 1'b1;
      end
    end
  end

`ifdef RX_CTRL_STALL_DROP_EN
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  logic [STALL_W-1:0] stall_cnt_reg;
  logic               stall_drop_reg;

  // The cycle that would bring the counter to STALL_LIMIT abandons the buffer.
  assign stall_hit = (state_reg == SEND) && !word_ready &&
                     (stall_cnt_reg == STALL_W'(STALL_LIMIT - 1));

  // Count consecutive stalled SEND cycles; any handshake or leaving SEND restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg != SEND) || word_ready) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  // Sticky record that a buffer was abandoned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_drop_reg <= 1'b0;
    end else if (status_clear) begin
      stall_drop_reg <= 1'b0;
    end else if (stall_hit) begin
      stall_drop_reg <= 1'b1;
    end
  end

  assign stall_drop = stall_drop_reg;
`else
  assign stall_hit = 1'b0;
`endif

  rx_err_counter #(.ERR_CNT_WIDTH(ERR_CNT_WIDTH)) u_parity_cnt (
    .clk    (clk),
    .reset  (reset),
    .err_in (parity_error),
    .clear  (status_clear),
    .count  (parity_err_count)
  );

  rx_err_counter #(.ERR_CNT_WIDTH(ERR_CNT_WIDTH)) u_stop_cnt (
    .clk    (clk),
    .reset  (reset),
    .err_in (stop_bit_error),
    .clear  (status_clear),
    .count  (stop_err_count)
  );

  assign data_parallel_rd_enable = (state_reg == CAPTURE);
  assign word_valid              = (state_reg == SEND);
  assign busy                    = (state_reg != IDLE);
  assign word_out                = (state_reg == SEND) ? shadow_reg[index_reg] : '0;
  assign overrun                 = overrun_reg;

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Directed bench for rx_drain_ctrl (N=2, W=7, ERR_CNT_WIDTH=8).
// Inputs change and outputs are sampled on the falling clock edge.
// Optional feature macro: RX_CTRL_STALL_DROP_EN (adds the stall-drop scenario).
module tb_rx_drain_ctrl;

`ifdef RX_CTRL_STALL_DROP_EN
  localparam int STALL_LIM = 16;
`else
  localparam int STALL_LIM = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_buffer_full;
  logic [13:0] data_parallel_in;
  logic        data_parallel_rd_enable;
  logic        parity_error;
  logic        stop_bit_error;
  logic [6:0]  word_out;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic [7:0]  parity_err_count;
  logic [7:0]  stop_err_count;
  logic        overrun;
  logic        status_clear;
`ifdef RX_CTRL_STALL_DROP_EN
  logic        stall_drop;
`endif

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  rx_drain_ctrl #(
    .NO_OF_WORS_IN_BUFFER (2),
    .NO_OF_DATA_BITS      (7),
    .ERR_CNT_WIDTH        (8),
    .STALL_LIMIT          (STALL_LIM)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .rx_buffer_full          (rx_buffer_full),
    .data_parallel_in        (data_parallel_in),
    .data_parallel_rd_enable (data_parallel_rd_enable),
    .parity_error            (parity_error),
    .stop_bit_error          (stop_bit_error),
    .word_out                (word_out),
    .word_valid              (word_valid),
    .word_ready              (word_ready),
    .busy                    (busy),
    .parity_err_count        (parity_err_count),
    .stop_err_count          (stop_err_count),
    .overrun                 (overrun),
`ifdef RX_CTRL_STALL_DROP_EN
    .stall_drop              (stall_drop),
`endif
    .status_clear            (status_clear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %-22s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset            = 1'b1;
    rx_buffer_full   = 1'b0;
    data_parallel_in = '0;
    parity_error     = 1'b0;
    stop_bit_error   = 1'b0;
    word_ready       = 1'b0;
    status_clear     = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_valid", word_valid, 0);
    check("rst_rd", data_parallel_rd_enable, 0);
    check("rst_word", word_out, 0);
    check("rst_overrun", overrun, 0);
    check("rst_par_cnt", parity_err_count, 0);
    reset = 1'b0;
    tick();

    // Buffer fill, consumer always ready
    data_parallel_in = 14'h2A55;
    rx_buffer_full   = 1'b1;
    word_ready       = 1'b1;
    tick();
    check("fill_rd", data_parallel_rd_enable, 1);
    check("fill_cap_valid", word_valid, 0);
    check("fill_cap_busy", busy, 1);
    rx_buffer_full = 1'b0;
    tick();
    check("fill_w0", word_out, 7'h55);
    check("fill_w0_valid", word_valid, 1);
    check("fill_w0_rd", data_parallel_rd_enable, 0);
    tick();
    check("fill_w1", word_out, 7'h54);
    check("fill_w1_valid", word_valid, 1);
    tick();
    check("fill_done_busy", busy, 0);
    check("fill_done_valid", word_valid, 0);

    // Back-pressure for 5 cycles
    word_ready     = 1'b0;
    rx_buffer_full = 1'b1;
    tick();
    check("bp_rd", data_parallel_rd_enable, 1);
    rx_buffer_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_word", word_out, 7'h55);
      check("bp_hold_valid", word_valid, 1);
      check("bp_hold_no_rd", data_parallel_rd_enable, 0);
    end
    word_ready = 1'b1;
    tick();
    check("bp_w1", word_out, 7'h54);
    tick();
    check("bp_done_busy", busy, 0);

    // Overrun: buffer refills while draining
    word_ready       = 1'b0;
    data_parallel_in = 14'h1234;
    rx_buffer_full   = 1'b1;
    tick();
    check("ovr_rd1", data_parallel_rd_enable, 1);
    rx_buffer_full = 1'b0;
    tick();
    check("ovr_w0_first", word_out, 7'h34);
    rx_buffer_full   = 1'b1;
    data_parallel_in = 14'h0A0B;
    tick();
    check("ovr_flag_set", overrun, 1);
    check("ovr_shadow_kept", word_out, 7'h34);
    word_ready = 1'b1;
    tick();
    check("ovr_w1_old", word_out, 7'h24);
    tick();
    check("ovr_idle_between", busy, 0);
    tick();
    check("ovr_rd2", data_parallel_rd_enable, 1);
    rx_buffer_full = 1'b0;
    tick();
    check("ovr_new_w0", word_out, 7'h0B);
    check("ovr_flag_sticky", overrun, 1);
    tick();
    check("ovr_new_w1", word_out, 7'h14);
    tick();
    check("ovr_done_busy", busy, 0);
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Error counters and saturation
    for (int i = 0; i < 3; i++) begin
      parity_error = 1'b1; tick();
      parity_error = 1'b0; tick();
    end
    check("par_cnt_3", parity_err_count, 8'd3);
    for (int i = 0; i < 297; i++) begin
      parity_error = 1'b1; tick();
      parity_error = 1'b0; tick();
    end
    check("par_cnt_sat", parity_err_count, 8'hFF);
    check("stop_cnt_idle", stop_err_count, 0);
    parity_error = 1'b1;
    status_clear = 1'b1;
    tick();
    check("par_clear_prio", parity_err_count, 0);
    parity_error = 1'b0;
    status_clear = 1'b0;
    tick();
    parity_error = 1'b1; tick();
    check("par_cnt_after_clr", parity_err_count, 8'd1);
    parity_error = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stop_bit_error = 1'b1; tick();
      stop_bit_error = 1'b0; tick();
    end
    check("stop_cnt_2", stop_err_count, 8'd2);

    // Reset asserted mid-SEND, full still high
    data_parallel_in = 14'h2A55;
    rx_buffer_full   = 1'b1;
    word_ready       = 1'b1;
    tick();
    check("mrst_rd", data_parallel_rd_enable, 1);
    tick();
    check("mrst_w0", word_out, 7'h55);
    tick();
    check("mrst_w1", word_out, 7'h54);
    reset = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_valid", word_valid, 0);
    check("mrst_word", word_out, 0);
    check("mrst_rd_low", data_parallel_rd_enable, 0);
    check("mrst_par_cnt", parity_err_count, 0);
    check("mrst_stop_cnt", stop_err_count, 0);
    tick();
    check("mrst_hold_rd", data_parallel_rd_enable, 0);
    reset = 1'b0;
    tick();
    check("mrst_recap_rd", data_parallel_rd_enable, 1);
    rx_buffer_full = 1'b0;
    tick();
    check("mrst_recap_w0", word_out, 7'h55);
    tick();
    check("mrst_recap_w1", word_out, 7'h54);
    tick();
    check("mrst_recap_done", busy, 0);

`ifdef RX_CTRL_STALL_DROP_EN
    // Stall timeout drops the rest of the buffer
    word_ready     = 1'b0;
    rx_buffer_full = 1'b1;
    tick();
    rx_buffer_full = 1'b0;
    tick();
    check("stall_w0", word_out, 7'h55);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("stall_still_valid", word_valid, 1);
    end
    check("stall_no_flag_yet", stall_drop, 0);
    tick();
    check("stall_dropped_busy", busy, 0);
    check("stall_flag", stall_drop, 1);
    word_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_w1", word_valid, 0);
      check("stall_no_rd", data_parallel_rd_enable, 0);
    end
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    check("stall_flag_clr", stall_drop, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
